// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem read at a time, a single-entry
// hold register toward the decoder, and PC redirect with drain of abandoned reads.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc_out,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] addr_q;
  logic [31:0] target;
  logic        capture;
  logic        retire;

  assign target = {redirect_pc[31:2], 2'b00};

  // The request address freezes while draining so the memory sees a stable read
  // even though pc has already moved to the redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state_next != DRAIN)
        addr_q <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst        <= 32'h0000_0000;
      pc_out      <= 32'h0000_0000;
      fetch_count <= 32'h0000_0000;
    end else begin
      if (capture) begin
        inst   <= imem_rdata;
        pc_out <= pc;
      end
      if (retire)
        fetch_count <= fetch_count + 32'd1;
    end
  end

  // Redirect wins over ack and ready in every state.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state)
      BOOT: begin
        state_next = FETCH;
        if (redirect)
          pc_next = target;
      end
      FETCH: begin
        if (redirect) begin
          pc_next    = target;
          state_next = imem_ack ? FETCH : DRAIN;
        end else if (imem_ack) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = target;
          state_next = FETCH;
        end else if (inst_ready) begin
          pc_next    = pc + 32'd4;
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      DRAIN: begin
        if (redirect)
          pc_next = target;
        if (imem_ack)
          state_next = FETCH;
      end
      default: state_next = BOOT;
    endcase
  end

  assign imem_req   = (state == FETCH) || (state == DRAIN);
  assign inst_valid = (state == HOLD);
  assign imem_addr  = addr_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: table-driven fetch/hold transactions with a
// scoreboard queue, followed by redirect, drain and reset corner sequences.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc_out;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          ackDelay;
    int          readyDelay;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[7];
  exp_t sbQ[$];

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .pc_out     (pc_out),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then advance to the following falling edge.
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic ready,
                               input logic redir, input logic [31:0] rpc);
    imem_ack    = ack;
    imem_rdata  = rdata;
    inst_ready  = ready;
    redirect    = redir;
    redirect_pc = rpc;
    @(negedge clk);
  endtask

  task automatic popCompare(input string tag);
    exp_t e;
    total++;
    if (sbQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s scoreboard: got empty queue required one entry", tag);
    end else begin
      total--;
      e = sbQ.pop_front();
      checkOutput({tag, " inst"}, inst, e.data);
      checkOutput({tag, " pc_out"}, pc_out, e.addr);
    end
  endtask

  initial begin
    vecs[0] = '{0, 0, 32'hFFFF_FFFC, 32'h0000_0013};
    vecs[1] = '{0, 0, 32'h0000_0000, 32'h0050_0093};
    vecs[2] = '{0, 0, 32'h0000_0004, 32'h0060_0113};
    vecs[3] = '{0, 0, 32'h0000_0008, 32'h0020_81B3};
    vecs[4] = '{3, 0, 32'h0000_000C, 32'h0000_0033};
    vecs[5] = '{0, 5, 32'h0000_0010, 32'hA5A5_5A5A};
    vecs[6] = '{1, 2, 32'h0000_0014, 32'h1234_5678};

    rst = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset imem_req", {31'd0, imem_req}, 32'd0);
    checkOutput("reset inst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("reset imem_addr", imem_addr, 32'hFFFF_FFFC);
    checkOutput("reset inst", inst, 32'd0);
    checkOutput("reset pc_out", pc_out, 32'd0);
    checkOutput("reset fetch_count", fetch_count, 32'd0);

    rst = 1'b0;
    #1;
    checkOutput("boot imem_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("v%0d fetch req", i), {31'd0, imem_req}, 32'd1);
      checkOutput($sformatf("v%0d fetch addr", i), imem_addr, vecs[i].addr);
      for (int k = 0; k < vecs[i].ackDelay; k++) begin
        applyStimulus(1'b0, 32'hDEAD_0000, 1'b0, 1'b0, '0);
        checkOutput($sformatf("v%0d wait req", i), {31'd0, imem_req}, 32'd1);
        checkOutput($sformatf("v%0d wait addr", i), imem_addr, vecs[i].addr);
      end
      sbQ.push_back('{vecs[i].addr, vecs[i].data});
      applyStimulus(1'b1, vecs[i].data, 1'b0, 1'b0, '0);
      imem_ack = 1'b0;
      checkOutput($sformatf("v%0d hold valid", i), {31'd0, inst_valid}, 32'd1);
      checkOutput($sformatf("v%0d hold req", i), {31'd0, imem_req}, 32'd0);
      for (int k = 0; k < vecs[i].readyDelay; k++) begin
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput($sformatf("v%0d stall valid", i), {31'd0, inst_valid}, 32'd1);
        checkOutput($sformatf("v%0d stall inst", i), inst, vecs[i].data);
        checkOutput($sformatf("v%0d stall pc_out", i), pc_out, vecs[i].addr);
        checkOutput($sformatf("v%0d stall req", i), {31'd0, imem_req}, 32'd0);
        checkOutput($sformatf("v%0d stall count", i), fetch_count, i);
      end
      popCompare($sformatf("v%0d", i));
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
      inst_ready = 1'b0;
      checkOutput($sformatf("v%0d count", i), fetch_count, i + 1);
      checkOutput($sformatf("v%0d valid drop", i), {31'd0, inst_valid}, 32'd0);
    end

    // Redirect while a read is outstanding: drain it, then fetch the aligned target.
    checkOutput("pre-drain addr", imem_addr, 32'h0000_0018);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h0000_0103);
    redirect = 1'b0;
    checkOutput("drain req", {31'd0, imem_req}, 32'd1);
    checkOutput("drain addr", imem_addr, 32'h0000_0018);
    checkOutput("drain valid", {31'd0, inst_valid}, 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("drain addr 2", imem_addr, 32'h0000_0018);
    applyStimulus(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, '0);
    imem_ack = 1'b0;
    checkOutput("post-drain valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("post-drain addr", imem_addr, 32'h0000_0100);
    checkOutput("post-drain req", {31'd0, imem_req}, 32'd1);
    sbQ.push_back('{32'h0000_0100, 32'h0000_0011});
    applyStimulus(1'b1, 32'h0000_0011, 1'b0, 1'b0, '0);
    imem_ack = 1'b0;
    checkOutput("redir hold valid", {31'd0, inst_valid}, 32'd1);
    popCompare("redir");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    inst_ready = 1'b0;
    checkOutput("redir count", fetch_count, 32'd8);
    checkOutput("redir next addr", imem_addr, 32'h0000_0104);

    // Redirect coinciding with ack: data dropped, straight back to FETCH.
    applyStimulus(1'b1, 32'hBEEF_BEEF, 1'b0, 1'b1, 32'h0000_0202);
    imem_ack = 1'b0; redirect = 1'b0;
    checkOutput("ack+redir valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("ack+redir req", {31'd0, imem_req}, 32'd1);
    checkOutput("ack+redir addr", imem_addr, 32'h0000_0200);
    checkOutput("ack+redir inst kept", inst, 32'h0000_0011);

    // Redirect with ready in HOLD squashes the transfer.
    applyStimulus(1'b1, 32'h0000_0022, 1'b0, 1'b0, '0);
    imem_ack = 1'b0;
    checkOutput("squash hold valid", {31'd0, inst_valid}, 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h0000_0040);
    inst_ready = 1'b0; redirect = 1'b0;
    checkOutput("squash count", fetch_count, 32'd8);
    checkOutput("squash addr", imem_addr, 32'h0000_0040);
    checkOutput("squash valid", {31'd0, inst_valid}, 32'd0);

    // Reset mid-request drops imem_req at once; redirect in BOOT steers the first fetch.
    rst = 1'b1;
    #1;
    checkOutput("midreset req", {31'd0, imem_req}, 32'd0);
    checkOutput("midreset addr", imem_addr, 32'hFFFF_FFFC);
    checkOutput("midreset count", fetch_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0305;
    #1;
    checkOutput("boot2 req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    checkOutput("boot redir req", {31'd0, imem_req}, 32'd1);
    checkOutput("boot redir addr", imem_addr, 32'h0000_0304);
    checkOutput("scoreboard drained", sbQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 Port imem_req  output  1  SHALL signal an outstanding instruction-memory read.
REQ-005 Port imem_addr  output  32  SHALL carry the byte address of the read (the current PC).
REQ-006 Port imem_ack  input  1  SHALL signal that imem_rdata is valid this cycle; it is ignored unless imem_req=1.
REQ-007 Port imem_rdata  input  32  SHALL carry the instruction word.
REQ-008 Port inst  output  32  SHALL carry the instruction word presented to the control decoder.
REQ-009 Port inst_valid  output  1  SHALL indicate that inst and pc_out are valid.
REQ-010 Port inst_ready  input  1  SHALL indicate that the decoder accepts inst this cycle.
REQ-011 Port pc_out  output  32  SHALL carry the address of the instruction on inst.
REQ-012 Port redirect  input  1  SHALL request a PC change (taken beq/bne).
REQ-013 Port redirect_pc  input  32  SHALL carry the redirect target.
REQ-014 Port fetch_count  output  32  SHALL count accepted instructions.

Function
REQ-015 The FSM SHALL have four states: BOOT, FETCH, HOLD, DRAIN.
REQ-016 BOOT SHALL drive imem_req=0 and inst_valid=0, and SHALL go unconditionally to FETCH on the next cycle.
REQ-017 FETCH behaviour:
- imem_req=1 and imem_addr=pc, both held stable until imem_ack.
- On imem_ack with no redirect: latch imem_rdata into inst and pc into pc_out, then go to HOLD.
- With no ack and no redirect: stay in FETCH.
REQ-018 HOLD behaviour:
- inst_valid=1 and imem_req=0; inst and pc_out held stable.
- On inst_ready with no redirect: the transfer completes, pc <= pc+4, and the state goes to FETCH.
- Otherwise: stay in HOLD.
REQ-019 DRAIN SHALL drive imem_req=1 with imem_addr unchanged from the abandoned request and inst_valid=0; on imem_ack the data SHALL be discarded and the state SHALL go to FETCH.
REQ-020 Redirect SHALL have priority over every other event, and pc SHALL load {redirect_pc[31:2],2'b00}:
- FETCH without ack: go to DRAIN; the outstanding request is completed, then discarded.
- FETCH with ack in the same cycle: discard the data and go to FETCH.
- HOLD, including when inst_ready=1 in the same cycle: the held instruction is squashed, the transfer does not count, and the state goes to FETCH.
- DRAIN: update pc and stay in DRAIN (or go to FETCH if imem_ack).
- BOOT: update pc; BOOT still proceeds to FETCH.
REQ-021 The PC arithmetic SHALL be 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 SHALL equal 32'h0000_0000.
REQ-022 fetch_count SHALL increment by 1 on each completed HOLD transfer (REQ-018) and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-023 inst_valid SHALL be 1 only in HOLD; imem_req SHALL be 1 only in FETCH and DRAIN.
REQ-024 At most one memory request SHALL be outstanding at any time.
REQ-025 Timing SHALL meet the following:
- Minimum latency from FETCH entry to inst_valid is 1 cycle, with imem_ack in the first FETCH cycle.
- Peak throughput is one instruction per 2 cycles.
- No combinational path from inputs to outputs.

Reset
REQ-026 Asserting rst SHALL immediately set:
- state=BOOT and pc=RESET_PC;
- inst=0, pc_out=0, inst_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_count=0.
REQ-027 Reset asserted mid-request SHALL abandon the request without a DRAIN; the memory responder shares rst.
REQ-028 The first FETCH after reset release SHALL occur on the second rising edge after rst falls, with the first edge in BOOT.

Verification
REQ-029 Reset release, memory acks in 1 cycle, inst_ready=1 always -> imem_addr sequence 0,4,8,...; inst_valid every other cycle; fetch_count=3 after three transfers.
REQ-030 imem_ack delayed 3 cycles -> imem_req and imem_addr held stable for all 3 cycles; inst equals imem_rdata (e.g. 32'h0000_0033) on entry to HOLD.
REQ-031 inst_ready=0 for 5 cycles in HOLD -> inst_valid, inst and pc_out stable; no new imem_req; fetch_count unchanged.
REQ-032 redirect with redirect_pc=32'h0000_0103 issued in FETCH with the ack 2 cycles later -> DRAIN; the returned word is discarded; the next imem_addr is 32'h0000_0100.
REQ-033 redirect together with inst_ready in HOLD (pc=8, redirect_pc=32'h40) -> fetch_count unchanged; the next imem_addr is 32'h40.
REQ-034 RESET_PC=32'hFFFF_FFFC, one transfer -> the next imem_addr is 0; rst asserted during FETCH -> imem_req=0 immediately.
